// File: rtl/p20_game_pkg.sv
// p20 game controller shared types.
// State encoding and counter width helpers.
package p20_game_pkg;

  typedef enum logic [1:0] {
    ST_OVER  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2,
    ST_PAUSE = 2'd3
  } state_e;

  function automatic int unsigned cnt_w(
    input int unsigned max_v
  );
    return (max_v < 1) ? 1 : $clog2(max_v + 1);
  endfunction

  function automatic int unsigned max_u(
    input int unsigned a,
    input int unsigned b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/p20_sat_counter.sv
// Up counter that stops at MAX.
// Clear wins over enable.
module p20_sat_counter #(
  parameter int unsigned MAX = 1,
  parameter int unsigned W   = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != MAX_V)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/p20_game_ctrl.sv
// p20 runner game-state controller: over/start/run/pause,
// restart re-arm, blink, obstacle latching, high score.
module p20_game_ctrl
  import p20_game_pkg::*;
#(
  parameter int unsigned START_TIME = 30000000,
  parameter int unsigned REARM_TIME = 100000,
  parameter int unsigned N_OBST     = 3,
  parameter int unsigned BLINK_BIT  = 22,
  parameter int unsigned SCORE_W    = 16
) (
  input  logic               clk,
  input  logic               sys_rst,
  input  logic               jump_in,
  input  logic               halt_in,
  input  logic               debug_in,
  input  logic               pause_in,
  input  logic               collision,
  input  logic [N_OBST-1:0]  obstacle_select,
  input  logic [N_OBST-1:0]  random,
  input  logic [SCORE_W-1:0] score,
  output logic               game_reset,
  output logic               game_halt,
  output logic               game_over,
  output logic               start_blink,
  output logic [N_OBST-1:0]  obstacle_type,
  output logic [SCORE_W-1:0] high_score,
  output logic               new_high,
  output logic [1:0]         state
);

  localparam int unsigned NJ_MAX = REARM_TIME + 1;
  localparam int unsigned NJ_W   = cnt_w(NJ_MAX);
  localparam int unsigned SC_MAX = START_TIME - 1;
  localparam int unsigned SC_W   =
    max_u(cnt_w(SC_MAX), BLINK_BIT + 1);
  localparam int unsigned BL_W   = BLINK_BIT + 1;

  localparam logic [NJ_W-1:0] NJ_ARM  = NJ_W'(REARM_TIME);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(SC_MAX);

  state_e             state_q;
  state_e             state_d;
  logic [SCORE_W-1:0] high_q;
  logic [SCORE_W-1:0] high_d;
  logic               new_high_q;
  logic               new_high_d;
  logic               pause_q;
  logic [BL_W-1:0]    blink_q;
  logic [BL_W-1:0]    blink_d;

  logic [NJ_W-1:0]    nj_ctr;
  logic [SC_W-1:0]    start_ctr;
  logic               pause_edge;
  logic               hit;

  p20_sat_counter #(
    .MAX (NJ_MAX),
    .W   (NJ_W)
  ) u_nj_ctr (
    .clk (clk),
    .rst (sys_rst),
    .clr (jump_in),
    .en  (1'b1),
    .cnt (nj_ctr)
  );

  p20_sat_counter #(
    .MAX (SC_MAX),
    .W   (SC_W)
  ) u_start_ctr (
    .clk (clk),
    .rst (sys_rst),
    .clr (game_reset),
    .en  (state_q == ST_START),
    .cnt (start_ctr)
  );

  assign pause_edge = pause_in & ~pause_q;
  assign hit        = collision & ~debug_in;

  assign game_reset = (state_q == ST_OVER) & jump_in &
                      (nj_ctr > NJ_ARM);

  always_comb begin
    state_d    = state_q;
    high_d     = high_q;
    new_high_d = new_high_q;
    blink_d    = blink_q + 1'b1;
    unique case (state_q)
      ST_OVER: begin
        if (game_reset) begin
          state_d    = ST_START;
          new_high_d = 1'b0;
        end
      end
      ST_START: begin
        if (start_ctr == SC_LAST) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // collision outranks a simultaneous pause press
        if (hit) begin
          state_d = ST_OVER;
          if (score > high_q) begin
            high_d     = score;
            new_high_d = 1'b1;
          end
        end else if (pause_edge) begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (pause_edge) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_OVER;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_q    <= ST_OVER;
      high_q     <= '0;
      new_high_q <= 1'b0;
      pause_q    <= 1'b0;
      blink_q    <= '0;
    end else begin
      state_q    <= state_d;
      high_q     <= high_d;
      new_high_q <= new_high_d;
      pause_q    <= pause_in;
      blink_q    <= blink_d;
    end
  end

  always_comb begin
    start_blink = 1'b1;
    unique case (state_q)
      ST_START: start_blink = start_ctr[BLINK_BIT];
      ST_PAUSE: start_blink = blink_q[BLINK_BIT];
      default:  start_blink = 1'b1;
    endcase
  end

  for (genvar i = 0; i < N_OBST; i++) begin : g_obst
    logic sel_q;
    logic type_q;
    logic type_d;

    assign type_d = (obstacle_select[i] & ~sel_q) ?
                    random[i] : type_q;

    always_ff @(posedge clk) begin
      if (sys_rst) begin
        sel_q  <= 1'b0;
        type_q <= 1'b0;
      end else begin
        sel_q  <= obstacle_select[i];
        type_q <= type_d;
      end
    end

    assign obstacle_type[i] = type_q;
  end

  assign game_over  = (state_q == ST_OVER);
  assign game_halt  = (state_q != ST_RUN) | halt_in;
  assign high_score = high_q;
  assign new_high   = new_high_q;
  assign state      = state_q;

endmodule

// File: doc/p20_game_ctrl.md
# p20_game_ctrl

Parametrised game-state controller for the p20 VGA runner game: owns the game-over/start/run/pause state machine, the restart re-arm timer, the start-countdown blink, per-channel obstacle-type latching and a high-score register. Sits between the top level and the jumping/scroll/score/rendering instances. It generalises the top-level control logic to N obstacle channels, configurable timings, a pause mode and high-score tracking.

## Interface
- `START_TIME`, 30000000: cycles of halted countdown after a restart.
- `REARM_TIME`, 100000: `jump_in` must be low for more than this many cycles before a restart is accepted.
- `N_OBST`, 3: number of obstacle channels.
- `BLINK_BIT`, 22: bit of the countdown counter that drives the blink.
- `SCORE_W`, 16: score width.
- `clk`  in  1  system clock; the only clock.
- `sys_rst`  in  1  synchronous, active-high reset.
- `jump_in`  in  1  player jump/restart button.
- `halt_in`  in  1  external freeze.
- `debug_in`  in  1  when high, collisions are ignored.
- `pause_in`  in  1  pause button; acts on its rising edge.
- `collision`  in  1  from rendering.
- `obstacle_select`  in  N_OBST  per-channel obstacle-active flags from rendering.
- `random`  in  N_OBST  RNG bits; bit i feeds channel i.
- `score`  in  SCORE_W  current score.
- `game_reset`  out  1  one-cycle restart pulse; combinational.
- `game_halt`  out  1  freezes the jumping, scroll and score blocks.
- `game_over`  out  1  high in state OVER.
- `start_blink`  out  1  sprite-visible enable for rendering.
- `obstacle_type`  out  N_OBST  latched per-channel obstacle variant.
- `high_score`  out  SCORE_W  best score since reset.
- `new_high`  out  1  the last game set a new high score.
- `state`  out  2  encoding: OVER=0, START=1, RUN=2, PAUSE=3.

## Operation
- **OVER** (reset state).
  - `game_reset = jump_in & (nj_ctr > REARM_TIME)`.
  - On `game_reset`: go to START, `start_ctr <= 0`, `new_high <= 0`.
- **START**
  - `start_ctr` increments each cycle.
  - When `start_ctr == START_TIME-1`, go to RUN.
  - Collisions are ignored.
- **RUN**
  - `collision & ~debug_in`: go to OVER. In the same cycle, if `score > high_score`, then `high_score <= score` and `new_high <= 1`. An equal score does not update.
  - Otherwise, a pause rising edge goes to PAUSE.
  - A collision has priority over a pause edge in the same cycle.
- **PAUSE**
  - A pause rising edge returns to RUN.
  - Collisions are ignored.
  - `jump_in` has no effect.
- **nj_ctr**
  - Cleared while `jump_in=1`; otherwise increments.
  - Saturates at REARM_TIME+1. Width is clog2(REARM_TIME+2).
  - Runs in every state.
- **Pause edge:** `pause_in & ~pause_q`, where `pause_q` is registered every cycle.
- **game_halt:** `(state != RUN) | halt_in`.
- **start_blink:** 1 in OVER and RUN; `start_ctr[BLINK_BIT]` in START; `blink_ctr[BLINK_BIT]` in PAUSE. `blink_ctr` is free-running and width BLINK_BIT+1.
- **Obstacle types:** for each channel i, on `obstacle_select[i] & ~sel_q[i]`, latch `obstacle_type[i] <= random[i]`. This happens in every state; `sel_q` is registered every cycle.

## Timing
- Reset values:
  - State OVER, so `game_over=1` and `game_halt=1`.
  - `game_reset=0`, `start_blink=1`.
  - `obstacle_type=0`, `high_score=0`, `new_high=0`.
  - All counters 0; `sel_q=0`, `pause_q=0`.
- All state changes take effect on the clock edge after the qualifying input. Outputs other than `game_reset` are registered state or decode from it.
- After `sys_rst` falls, a restart is possible only once `jump_in` has been low for REARM_TIME+1 cycles.
- The restart pulse lasts one cycle: the state leaves OVER on that edge, so `game_reset` drops even if `jump_in` stays high.
- START lasts exactly START_TIME cycles. `game_halt` falls on the first RUN cycle.
- `sys_rst` mid-game returns to OVER immediately on the next edge and clears `high_score`.

## Structure
- Package `p20_game_pkg`: state enum (`ST_OVER`, `ST_START`, `ST_RUN`, `ST_PAUSE`) and a clog2-based width helper.
- Sub-module `p20_sat_counter`, parametrised on MAX with clear/enable inputs, instantiated for `nj_ctr` and `start_ctr`.
- Obstacle latching is a generate loop over `N_OBST`.

## Test plan
All scenarios use START_TIME=8, REARM_TIME=4, N_OBST=3, BLINK_BIT=1.
1. Reset, `jump_in` held high -> no `game_reset`. Release for 5 cycles, then press -> `game_reset` pulses one cycle, state=START. `game_halt` stays 1 for 8 cycles, then state=RUN and `game_halt=0`.
2. In START, `start_blink` follows `start_ctr[1]`: 0,0,1,1,0,0,1,1. A collision during START is ignored.
3. In RUN with score=42 and high_score=0, assert `collision` -> state=OVER, high_score=42, new_high=1. Next game, collide at score=42 -> high_score stays 42, new_high=0.
4. RUN, `debug_in=1`, `collision=1` -> stays RUN. `debug_in=0` -> OVER next edge.
5. RUN, pulse `pause_in` -> PAUSE with `game_halt=1`. Hold `pause_in` high -> stays PAUSE. Second rising edge -> RUN. Pause edge and collision in the same cycle -> OVER.
6. `random=3'b101`, `obstacle_select` 000->111 -> `obstacle_type=101`. Change `random` while select stays high -> no change. Assert `sys_rst` mid-RUN -> all outputs at their reset values.
